// File: rtl/mem_req_arbiter.sv
// N-requester arbiter for the shared memory port: one registered request slot,
// fixed-priority or round-robin selection, in-order read responses routed by an ID FIFO.
package mem_req_arbiter_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;
endpackage

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_rd_valid_i,
  input  logic [NUM_REQ-1:0]                   req_wr_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wr_data_i,
  input  access_size_t [NUM_REQ-1:0]           req_size_i,
  output logic [NUM_REQ-1:0]                   req_grant_o,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_data_o,
  output logic                                 mem_rd_req_valid_o,
  output logic                                 mem_wr_req_valid_o,
  output logic                                 mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wr_data_o,
  output access_size_t                         mem_req_size_o,
  input  logic                                 mem_req_ready_i,
  input  logic                                 mem_data_valid_i,
  input  logic [DATA_WIDTH-1:0]                mem_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_unexpected_rsp_o
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNTW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } slot_state_t;

  slot_state_t            r_state;
  logic                   r_rd_valid;
  logic                   r_wr_valid;
  logic                   r_is_instr;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  access_size_t           r_size;
  logic [IDW-1:0]         r_last;

  logic [IDW-1:0]         r_fifo [MAX_OUTSTANDING];
  logic [PTRW-1:0]        r_wr_ptr;
  logic [PTRW-1:0]        r_rd_ptr;
  logic [CNTW-1:0]        r_count;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_data;
  logic                   r_err;

  logic                   w_has_space;
  logic [NUM_REQ-1:0]     w_eligible;
  logic                   w_slot_open;
  logic                   w_found;
  logic [IDW-1:0]         w_winner;
  logic                   w_capture;
  logic                   w_cap_is_wr;
  logic                   w_push;
  logic                   w_pop;
  logic [NUM_REQ-1:0]     w_grant;

  // Reads are held off on the registered count only, so a same-cycle pop never frees a slot early.
  assign w_has_space = (r_count < CNTW'(MAX_OUTSTANDING));
  assign w_eligible  = req_wr_valid_i | (req_rd_valid_i & {NUM_REQ{w_has_space}});
  assign w_slot_open = ~rst_i & ((r_state == S_EMPTY) | mem_req_ready_i);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (RR_MODE != 0) ? ((int'(r_last) + 1 + k) % NUM_REQ) : k;
      if (!w_found && w_eligible[idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  assign w_capture   = w_slot_open & w_found;
  assign w_cap_is_wr = req_wr_valid_i[w_winner];
  assign w_grant     = w_capture ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_push      = w_capture & ~w_cap_is_wr;
  assign w_pop       = mem_data_valid_i & (r_count != '0);

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_EMPTY;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_is_instr <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_size     <= SIZE_BYTE;
      r_last     <= IDW'(NUM_REQ - 1);
    end else if (w_capture) begin
      r_state    <= S_HELD;
      r_rd_valid <= ~w_cap_is_wr;
      r_wr_valid <= w_cap_is_wr;
      r_is_instr <= (w_winner == '0);
      r_addr     <= req_addr_i[w_winner];
      r_wr_data  <= req_wr_data_i[w_winner];
      r_size     <= req_size_i[w_winner];
      r_last     <= w_winner;
    end else if ((r_state == S_HELD) && mem_req_ready_i) begin
      r_state    <= S_EMPTY;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
    end
  end

  // NOTE: ID storage has no reset; entries are only read between a push and its pop, and the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr   <= ptr_next(r_rd_ptr);
        r_rsp_data <= mem_data_i;
      end
      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << r_fifo[r_rd_ptr]) : '0;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem_data_valid_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_grant_o          = w_grant;
  assign rsp_valid_o          = r_rsp_valid;
  assign rsp_data_o           = r_rsp_data;
  assign mem_rd_req_valid_o   = r_rd_valid;
  assign mem_wr_req_valid_o   = r_wr_valid;
  assign mem_req_is_instr_o   = r_is_instr;
  assign mem_req_addr_o       = r_addr;
  assign mem_wr_data_o        = r_wr_data;
  assign mem_req_size_o       = r_size;
  assign outstanding_o        = r_count;
  assign err_unexpected_rsp_o = r_err;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-requester arbiter for the single shared instruction/data memory port.
- Generalises the fixed two-way fetch-over-mem steering at the cpu top to NUM_REQ channels.
- Selectable fixed-priority or round-robin arbitration, with a registered request slot and multiple in-flight reads.
- Read responses return in order and are routed back to the issuing requester through an ID FIFO.

Parameters:
- NUM_REQ, 2: number of requesters; index 0 is the fetch stage by convention.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: read/write data width.
- MAX_OUTSTANDING, 4: read IDs held in flight (ID FIFO depth, power of two, ≥1).
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_rd_valid_i  in  NUM_REQ  per-requester read request
- req_wr_valid_i  in  NUM_REQ  per-requester write request
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  per-requester address
- req_wr_data_i  in  NUM_REQ x DATA_WIDTH  per-requester write data
- req_size_i  in  NUM_REQ x access_size_t  per-requester access size
- req_grant_o  out  NUM_REQ  one-hot pulse: that requester's request was captured this cycle
- rsp_valid_o  out  NUM_REQ  one-hot pulse: read data for that requester on rsp_data_o
- rsp_data_o  out  DATA_WIDTH  registered read data
- mem_rd_req_valid_o  out  1  slot holds a read
- mem_wr_req_valid_o  out  1  slot holds a write
- mem_req_is_instr_o  out  1  slot owner is requester 0
- mem_req_addr_o  out  ADDR_WIDTH  slot address
- mem_wr_data_o  out  DATA_WIDTH  slot write data
- mem_req_size_o  out  access_size_t  slot access size
- mem_req_ready_i  in  1  memory accepts the slot request this cycle
- mem_data_valid_i  in  1  in-order read response valid
- mem_data_i  in  DATA_WIDTH  read response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  ID FIFO occupancy
- err_unexpected_rsp_o  out  1  sticky: response arrived with ID FIFO empty

Behaviour:
- Reset (rst_i=1 at clk edge): slot empty.
  - All mem_*_valid_o, req_grant_o, rsp_valid_o and err_unexpected_rsp_o are 0.
  - rsp_data_o and mem_req_addr_o/mem_wr_data_o/mem_req_size_o are 0.
  - FIFO is emptied; outstanding_o is 0.
  - RR pointer is set so requester 0 has top priority.
  - Reset mid-operation discards in-flight IDs. Responses arriving after reset set the error flag.
- Slot states: EMPTY or HELD.
  - The slot can capture a request in a cycle when it is EMPTY, or when it is HELD and mem_req_ready_i=1 (back-to-back capture, no bubble).
- Eligibility: requester i is eligible if req_wr_valid_i[i]=1, or if req_rd_valid_i[i]=1 and outstanding_o < MAX_OUTSTANDING.
  - There is no full bypass: a pop in the same cycle does not make a read eligible when the FIFO is full.
  - If rd and wr are both asserted for one requester, the write wins. The read stays pending.
- Arbitration is combinational among eligible requesters.
  - RR_MODE=0: lowest eligible index wins.
  - RR_MODE=1: search starts at last-granted+1 mod NUM_REQ. The pointer updates only on a grant.
- On capture:
  - req_grant_o[winner]=1 for that cycle.
  - Address, data, size, rd/wr and ID are registered into the slot; mem_*_o are valid the next cycle.
  - A captured read pushes its ID into the FIFO in the same edge.
  - The requester must treat a grant as consumed and advance or drop its request the next cycle.
- While HELD without mem_req_ready_i, all mem_*_o hold stable and no grant is issued.
- Writes complete when accepted and produce no response.
- Response path:
  - mem_data_valid_i=1 with the FIFO non-empty pops the head ID.
  - The next cycle, rsp_valid_o[ID]=1 and rsp_data_o=mem_data_i. Latency is 1 cycle.
- mem_data_valid_i=1 with the FIFO empty: data is dropped, err_unexpected_rsp_o sets, and it stays set until reset.
- A push and a pop in the same cycle leave occupancy unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o is registered occupancy, counting reads captured but not yet responded to. This includes a read still sitting in the slot.
- mem_req_is_instr_o = (slot ID == 0).

Test Plan:
- Reset then idle: all outputs 0. Then req 0 reads 0x100: grant[0] pulses at cycle 0, mem_rd_req_valid_o=1 with addr 0x100 at cycle 1, ready at cycle 1. mem_data_valid_i with 0xDEADBEEF at cycle 3 -> rsp_valid_o[0] and rsp_data_o=0xDEADBEEF at cycle 4.
- RR_MODE=1, NUM_REQ=3, all three read continuously, ready always 1, responses delayed -> grant order 0,1,2,0. Responses routed in the same order.
- RR_MODE=0, req 0 and req 1 both write continuously -> req 0 granted every cycle; req 1 is starved. Under RR_MODE=1 they alternate.
- MAX_OUTSTANDING=2, req 1 issues 3 reads with no responses -> two grants, then outstanding_o=2 and no further read grant. A write from req 0 is still granted. The third read is granted the cycle after the first response pops.
- Slot HELD with ready=0 for 5 cycles -> mem_*_o stable and no grants. ready=1 with another requester pending -> new capture in the same cycle, valid the next cycle with no gap.
- mem_data_valid_i with the FIFO empty -> no rsp_valid_o and err_unexpected_rsp_o=1 thereafter. Asserting rst_i with 2 reads outstanding -> outstanding_o=0 and err cleared the next cycle.
